// File: rtl/tree_sum_accumulator_if.sv
// tree_sum_accumulator_if: handshake bundle for the tree-sum accumulator.
//   in_valid/in_ready/in_data/in_last    : beat input (one tree sum per accept)
//   out_valid/out_ready/out_data/out_count : accumulated result with backpressure
// Modports: master = producer/consumer side (testbench), slave = accumulator side.
// IN_WIDTH and BEATS must match the parameters of the attached accumulator.
interface tree_sum_accumulator_if #(
    parameter int unsigned IN_WIDTH = 11,
    parameter int unsigned BEATS    = 4
);
    localparam int unsigned OUT_WIDTH = IN_WIDTH + $clog2(BEATS);
    localparam int unsigned CNT_WIDTH = $clog2(BEATS) + 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0] out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/tree_sum_accumulator.sv
// tree_sum_accumulator: sums up to BEATS incoming tree sums per group (fewer if a
// beat carries in_last) and presents the registered total with its beat count.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : tree_sum_accumulator_if.slave (input beats, output results)
module tree_sum_accumulator #(
    parameter int unsigned IN_WIDTH = 11,
    parameter int unsigned BEATS    = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    tree_sum_accumulator_if.slave bus
);
    localparam int unsigned OUT_WIDTH = IN_WIDTH + $clog2(BEATS);
    localparam int unsigned CNT_WIDTH = $clog2(BEATS) + 1;

    typedef enum logic [0:0] {StAccum, StHold} state_e;

    state_e               state_q;
    logic [OUT_WIDTH-1:0] acc_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [OUT_WIDTH-1:0] out_data_q;
    logic [CNT_WIDTH-1:0] out_count_q;

    logic                 accept;
    logic                 xfer;
    logic                 done;
    logic [OUT_WIDTH-1:0] sum;
    logic [CNT_WIDTH-1:0] cnt_next;

    // In HOLD the result is already latched, so a new beat may enter exactly
    // when the result leaves: this keeps group boundaries bubble-free.
    assign bus.in_ready  = (state_q == StAccum) | bus.out_ready;
    assign bus.out_valid = (state_q == StHold);
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;

    always_comb begin
        accept   = bus.in_valid & bus.in_ready;
        xfer     = (state_q == StHold) & bus.out_ready;
        // acc/cnt are cleared on completion, so in HOLD this starts a new group.
        sum      = ((cnt_q == '0) ? '0 : acc_q) + OUT_WIDTH'(bus.in_data);
        cnt_next = cnt_q + CNT_WIDTH'(1);
        done     = bus.in_last | (cnt_next == CNT_WIDTH'(BEATS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StAccum;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else if (accept) begin
            // An accept while in HOLD implies a simultaneous transfer.
            if (done) begin
                out_data_q  <= sum;
                out_count_q <= cnt_next;
                acc_q       <= '0;
                cnt_q       <= '0;
                state_q     <= StHold;
            end else begin
                acc_q   <= sum;
                cnt_q   <= cnt_next;
                state_q <= StAccum;
            end
        end else if (xfer) begin
            state_q <= StAccum;
        end
    end
endmodule

// File: doc/tree_sum_accumulator.md
Name: tree_sum_accumulator

Overview:
- Downstream consumer of the adder-tree sum output.
- Accepts one tree sum per beat over a valid/ready handshake and accumulates BEATS beats, or fewer if terminated early by in_last.
- Presents the registered total on a valid/ready output port with backpressure.
- Turns a single-cycle reduction tree into a multi-beat dot-product/checksum reducer.

Parameters:
- IN_WIDTH, 11, width of each incoming tree sum. Matches a TREE_SIZE=4, DATA_SIZE=8 tree: DATA_SIZE+$clog2(TREE_SIZE)+1.
- BEATS, 4, maximum beats per accumulation; any integer >= 2.
- OUT_WIDTH, derived localparam IN_WIDTH+$clog2(BEATS), accumulator and result width; not overridable.
- CNT_WIDTH, derived localparam $clog2(BEATS)+1, beat-counter width.

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  IN_WIDTH  unsigned tree sum.
- in_last  input  1  final beat of this group; sampled only on accept.
- out_valid  output  1  out_data/out_count valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  OUT_WIDTH  unsigned accumulated total.
- out_count  output  CNT_WIDTH  number of beats summed, 1..BEATS.

Behaviour:
- One clock (clk); reset rst_n is asynchronous, active-low. Assertion immediately clears all state regardless of clock.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_count=0, internal acc=0, cnt=0, state=ACCUM.
- Input accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
- State ACCUM (out_valid=0, in_ready=1):
  - On accept, acc <= (cnt==0 ? in_data : acc+in_data), zero-extended to OUT_WIDTH; cnt <= cnt+1.
  - If the accepted beat has in_last=1, or cnt+1==BEATS: out_data <= final sum, out_count <= cnt+1, acc/cnt <= 0, state -> HOLD.
  - No accept: hold all state; idle cycles between beats are allowed.
- State HOLD (out_valid=1):
  - in_ready = out_ready, i.e. pass-through backpressure.
  - out_data/out_count stay stable until the transfer.
  - On transfer with no simultaneous accept: state -> ACCUM.
  - On transfer with a simultaneous accept: the accepted beat starts a new group (acc <= in_data, cnt <= 1) and state -> ACCUM. If that beat has in_last=1, or BEATS==1-equivalent completion applies, go directly back to HOLD with the new result; back-to-back single-beat groups sustain one result per cycle.
- Latency: out_valid rises the cycle after the completing beat is accepted (1 cycle). Throughput: one beat per cycle sustained, with no bubble across group boundaries when out_ready=1.
- Arithmetic: unsigned, no saturation. OUT_WIDTH guarantees no overflow: BEATS*(2^IN_WIDTH-1) fits.
- in_last on a beat that also reaches BEATS: single completion, no extra empty group.
- in_data/in_last ignored when in_valid=0, or when in_ready=0.
- Reset mid-group or while in HOLD: partial sum and pending result are discarded; no output is produced for that group.
- out_valid never deasserts without a transfer, except on reset.

Test Plan:
- Reset then 4 beats 10,20,30,40 with in_valid every cycle, in_last=0, out_ready=1 -> out_valid for exactly one cycle, one cycle after beat 4; out_data=100, out_count=4.
- Max values: 4 beats of 2047 -> out_data=8188 (13 bits, no wrap), out_count=4.
- Early end: beats 5,7 with in_last on 7 -> out_data=12, out_count=2; next group starts from 0.
- Backpressure: complete group (sum 100), hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 and out_data stable at 100 throughout. Then raise out_ready with in_data=9 presented -> transfer and accept in the same cycle; the next group's sum includes 9 as its first beat.
- Back-to-back in_last=1 beats 3,4,5 with out_ready=1 -> out_valid high 3 consecutive cycles; out_data 3,4,5; each out_count=1.
- Assert rst_n=0 asynchronously mid-cycle after 2 beats of a group -> outputs go to reset values immediately. After release, 4 beats of 1 -> out_data=4, proving no residue from the discarded partial sum.
